// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Sequential instruction fetch stage. It keeps a fetch request open to
//   instruction memory and accepts one instruction per acknowledged cycle.
//   It also follows branch/jump redirects and freezes while downstream
//   asserts stall.
//
// Ports
//   f_clk, f_rst_n  : clock (rising edge) / async active-low reset
//   i_instr, i_ack  : instruction word and acknowledge from memory
//   change_pc       : redirect request; alu_pc_value is the redirect target
//   i_stall         : downstream stall, freezes all state
//   o_syn           : fetch request strobe (high continuously out of reset)
//   o_addr_instr    : address of the pending fetch request
//   o_instr, pc     : last accepted instruction and its address
//   o_ce            : one-cycle valid for the next stage per accepted word
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter int I_WIDTH  = 32,
    parameter int A_WIDTH  = 32,
    parameter int PC_WIDTH = 32
) (
    input  logic                f_clk,
    input  logic                f_rst_n,
    input  logic [I_WIDTH-1:0]  i_instr,
    input  logic                i_ack,
    input  logic                change_pc,
    input  logic [PC_WIDTH-1:0] alu_pc_value,
    input  logic                i_stall,
    output logic                o_syn,
    output logic [A_WIDTH-1:0]  o_addr_instr,
    output logic [I_WIDTH-1:0]  o_instr,
    output logic [PC_WIDTH-1:0] pc,
    output logic                o_ce
);

    logic [A_WIDTH-1:0]  r_addr;
    logic [I_WIDTH-1:0]  r_instr;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_ce;
    logic                r_syn;

    logic [A_WIDTH-1:0]  w_redirect_addr;
    logic [PC_WIDTH-1:0] w_pc_load;
    logic [A_WIDTH-1:0]  w_addr_next;
    logic                w_accept;

    // PC-domain and address-domain values may differ in width: zero-extend
    // or truncate. Low bits pass unmodified, so there is no alignment check.
    generate
        if (PC_WIDTH >= A_WIDTH) begin : g_pc_wide
            assign w_redirect_addr = alu_pc_value[A_WIDTH-1:0];
            assign w_pc_load       = {{(PC_WIDTH-A_WIDTH){1'b0}}, r_addr};
        end else begin : g_addr_wide
            assign w_redirect_addr = {{(A_WIDTH-PC_WIDTH){1'b0}}, alu_pc_value};
            assign w_pc_load       = r_addr[PC_WIDTH-1:0];
        end
    endgenerate

    // Increment wraps naturally modulo 2^A_WIDTH.
    assign w_addr_next = r_addr + A_WIDTH'(4);
    // The strobe has to be up before an ack counts. This keeps an ack on the
    // very first edge after reset from being taken as an accept.
    assign w_accept    = r_syn & i_ack & ~i_stall & ~change_pc;

    always_ff @(posedge f_clk or negedge f_rst_n) begin
        if (!f_rst_n) begin
            r_addr  <= '0;
            r_instr <= '0;
            r_pc    <= '0;
            r_ce    <= 1'b0;
            r_syn   <= 1'b0;
        end else begin
            // Once out of reset the strobe never drops. Under stall the
            // register is still loaded, but with the value it already holds.
            r_syn <= 1'b1;
            if (change_pc) begin
                // Redirect wins over stall and discards any same-cycle ack.
                r_addr <= w_redirect_addr;
                r_ce   <= 1'b0;
            end else if (i_stall) begin
                // Freeze: o_ce keeps its value too, so a pending valid stays
                // visible until downstream can take it.
            end else if (w_accept) begin
                r_instr <= i_instr;
                r_pc    <= w_pc_load;
                r_ce    <= 1'b1;
                r_addr  <= w_addr_next;
            end else begin
                r_ce <= 1'b0;
            end
        end
    end

    assign o_syn        = r_syn;
    assign o_addr_instr = r_addr;
    assign o_instr      = r_instr;
    assign pc           = r_pc;
    assign o_ce         = r_ce;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        f_clk = 1'b0;
    logic        f_rst_n;
    logic [31:0] i_instr;
    logic        i_ack;
    logic        change_pc;
    logic [31:0] alu_pc_value;
    logic        i_stall;
    logic        o_syn;
    logic [31:0] o_addr_instr;
    logic [31:0] o_instr;
    logic [31:0] pc;
    logic        o_ce;

    instruction_fetch #(.I_WIDTH(32), .A_WIDTH(32), .PC_WIDTH(32)) dut (
        .f_clk(f_clk), .f_rst_n(f_rst_n), .i_instr(i_instr), .i_ack(i_ack),
        .change_pc(change_pc), .alu_pc_value(alu_pc_value), .i_stall(i_stall),
        .o_syn(o_syn), .o_addr_instr(o_addr_instr), .o_instr(o_instr),
        .pc(pc), .o_ce(o_ce)
    );

    always #5 f_clk = ~f_clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_addr;
    logic        exp_syn;

    // Drive one cycle of stimulus and advance the reference model. Sampling
    // happens 1 ns after the rising edge.
    task automatic cyc(input logic ack, input logic [31:0] instr, input logic stall,
                       input logic chg, input logic [31:0] tgt);
        i_ack = ack; i_instr = instr; i_stall = stall;
        change_pc = chg; alu_pc_value = tgt;
        if (chg) begin
            exp_addr = tgt;
        end else if (!stall && ack && exp_syn) begin
            sb.push_back('{instr: instr, pc: exp_addr});
            exp_addr = exp_addr + 32'd4;
        end
        exp_syn = 1'b1;
        @(posedge f_clk); #1;
    endtask

    task automatic test_reset();
        exp_t e;
        f_rst_n = 1'b0; i_ack = 1'b0; i_instr = '0; i_stall = 1'b0;
        change_pc = 1'b0; alu_pc_value = '0;
        exp_addr = '0; exp_syn = 1'b0;
        repeat (2) @(posedge f_clk);
        #1;
        n_chk++;
        if ({o_syn, o_ce, o_addr_instr, o_instr, pc} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got syn=%b ce=%b addr=%h instr=%h pc=%h, want all 0",
                     o_syn, o_ce, o_addr_instr, o_instr, pc);
        end
        f_rst_n = 1'b1;
        // An ack on the first edge must not be taken: the strobe is not up yet.
        cyc(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
        n_chk++;
        if (o_syn !== 1'b1 || o_addr_instr !== 32'h0 || o_ce !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got syn=%b addr=%h ce=%b, want syn=1 addr=0 ce=0",
                     o_syn, o_addr_instr, o_ce);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        exp_t e;
        words[0] = 32'hA0A0_A0A0; words[1] = 32'hB1B1_B1B1; words[2] = 32'hC2C2_C2C2;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, words[k], 1'b0, 1'b0, 32'h0);
            n_chk++;
            if (o_ce !== 1'b1 || sb.size() == 0) begin
                n_err++;
                $display("FAIL seq_ce[%0d]: got ce=%b, want 1 (queue %0d)", k, o_ce, sb.size());
            end else begin
                e = sb.pop_front();
                if (o_instr !== e.instr || pc !== e.pc) begin
                    n_err++;
                    $display("FAIL seq_data[%0d]: got instr=%h pc=%h, want instr=%h pc=%h",
                             k, o_instr, pc, e.instr, e.pc);
                end
            end
            cyc(1'b0, 32'hDEAD_0000, 1'b0, 1'b0, 32'h0);
            n_chk++;
            if (o_ce !== 1'b0 || o_instr !== words[k]) begin
                n_err++;
                $display("FAIL seq_bubble[%0d]: got ce=%b instr=%h, want ce=0 instr=%h",
                         k, o_ce, o_instr, words[k]);
            end
        end
        n_chk++;
        if (o_addr_instr !== 32'hC || o_addr_instr !== exp_addr) begin
            n_err++;
            $display("FAIL seq_addr: got %h, want 0000000c", o_addr_instr);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 32'hBAD0_0000 + k, 1'b1, 1'b0, 32'h0);
            n_chk++;
            if (o_addr_instr !== 32'hC || o_instr !== 32'hC2C2_C2C2 || pc !== 32'h8 || o_ce !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got addr=%h instr=%h pc=%h ce=%b, want c/c2c2c2c2/8/0",
                         k, o_addr_instr, o_instr, pc, o_ce);
            end
        end
        cyc(1'b1, 32'hD3D3_D3D3, 1'b0, 1'b0, 32'h0);
        n_chk++;
        if (o_ce !== 1'b1 || sb.size() == 0) begin
            n_err++;
            $display("FAIL stall_release_ce: got ce=%b, want 1", o_ce);
        end else begin
            e = sb.pop_front();
            if (o_instr !== e.instr || pc !== 32'hC || o_addr_instr !== 32'h10) begin
                n_err++;
                $display("FAIL stall_release: got instr=%h pc=%h addr=%h, want %h/0000000c/00000010",
                         o_instr, pc, o_addr_instr, e.instr);
            end
        end
        // A stall right after an accept freezes o_ce high as well.
        cyc(1'b1, 32'hBAD1_1111, 1'b1, 1'b0, 32'h0);
        n_chk++;
        if (o_ce !== 1'b1 || o_instr !== 32'hD3D3_D3D3 || o_addr_instr !== 32'h10) begin
            n_err++;
            $display("FAIL stall_ce_hold: got ce=%b instr=%h addr=%h, want 1/d3d3d3d3/00000010",
                     o_ce, o_instr, o_addr_instr);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        // Redirect with a simultaneous ack: the ack is dropped.
        cyc(1'b1, 32'h9999_9999, 1'b0, 1'b1, 32'h100);
        n_chk++;
        if (o_addr_instr !== 32'h100 || o_ce !== 1'b0 || o_instr !== 32'hD3D3_D3D3) begin
            n_err++;
            $display("FAIL redirect: got addr=%h ce=%b instr=%h, want 00000100/0/d3d3d3d3",
                     o_addr_instr, o_ce, o_instr);
        end
        cyc(1'b1, 32'hE4E4_E4E4, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (o_ce !== 1'b1 || sb.size() == 0) begin
                n_err++;
                $display("FAIL b2b_ce[%0d]: got ce=%b, want 1", k, o_ce);
            end else begin
                e = sb.pop_front();
                if (o_instr !== e.instr || pc !== e.pc) begin
                    n_err++;
                    $display("FAIL b2b_data[%0d]: got instr=%h pc=%h, want %h/%h",
                             k, o_instr, pc, e.instr, e.pc);
                end
            end
            if (k == 0) cyc(1'b1, 32'hF5F5_F5F5, 1'b0, 1'b0, 32'h0);
        end
        n_chk++;
        if (pc !== 32'h104 || o_addr_instr !== 32'h108) begin
            n_err++;
            $display("FAIL b2b_addr: got pc=%h addr=%h, want 00000104/00000108", pc, o_addr_instr);
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_wrap();
        exp_t e;
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cyc(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
        n_chk++;
        if (o_ce !== 1'b1 || sb.size() == 0) begin
            n_err++;
            $display("FAIL wrap_ce: got ce=%b, want 1", o_ce);
        end else begin
            e = sb.pop_front();
            if (o_instr !== 32'h1111_1111 || pc !== 32'hFFFF_FFFC || o_addr_instr !== 32'h0 ||
                pc !== e.pc) begin
                n_err++;
                $display("FAIL wrap: got instr=%h pc=%h addr=%h, want 11111111/fffffffc/00000000",
                         o_instr, pc, o_addr_instr);
            end
        end
        // A redirect is taken even while stalled.
        cyc(1'b1, 32'h2222_2222, 1'b1, 1'b1, 32'h203);
        n_chk++;
        if (o_addr_instr !== 32'h203 || o_ce !== 1'b0 || o_instr !== 32'h1111_1111) begin
            n_err++;
            $display("FAIL redirect_stall: got addr=%h ce=%b instr=%h, want 00000203/0/11111111",
                     o_addr_instr, o_ce, o_instr);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        cyc(1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
        if (sb.size() != 0) e = sb.pop_front();
        #2 f_rst_n = 1'b0;
        #1;
        n_chk++;
        if ({o_syn, o_ce, o_addr_instr, o_instr, pc} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got syn=%b ce=%b addr=%h instr=%h pc=%h, want all 0",
                     o_syn, o_ce, o_addr_instr, o_instr, pc);
        end
        sb.delete();
        exp_addr = '0; exp_syn = 1'b0;
        i_ack = 1'b0;
        @(posedge f_clk); #1;
        f_rst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        n_chk++;
        if (o_ce !== 1'b1 || sb.size() == 0) begin
            n_err++;
            $display("FAIL restart_ce: got ce=%b, want 1", o_ce);
        end else begin
            e = sb.pop_front();
            if (o_instr !== e.instr || pc !== 32'h0 || o_addr_instr !== 32'h4) begin
                n_err++;
                $display("FAIL restart: got instr=%h pc=%h addr=%h, want 12345678/00000000/00000004",
                         o_instr, pc, o_addr_instr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
